// File: rtl/funct_generator_fifo_reader_if.sv
// FIFO-side and DAC-side signal bundle of the sample FIFO reader.
// master drives control/FIFO inputs, slave is the reader itself.
interface funct_generator_fifo_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  en_i;
  logic [DIV_WIDTH-1:0]  clk_div_i;
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rd_en_o;
  logic                  dac_csn_o;
  logic                  dac_sclk_o;
  logic                  dac_sdata_o;
  logic                  busy_o;
  logic                  underrun_o;
  logic [CNT_WIDTH-1:0]  frame_cnt_o;

  modport master (
    output en_i, clk_div_i, fifo_empty_i, fifo_data_i,
    input  fifo_rd_en_o, dac_csn_o, dac_sclk_o, dac_sdata_o,
    input  busy_o, underrun_o, frame_cnt_o
  );

  modport slave (
    input  en_i, clk_div_i, fifo_empty_i, fifo_data_i,
    output fifo_rd_en_o, dac_csn_o, dac_sclk_o, dac_sdata_o,
    output busy_o, underrun_o, frame_cnt_o
  );
endinterface

// File: rtl/funct_generator_fifo_reader.sv
// Pops samples from the generator FIFO and shifts them MSB-first
// onto a csn/sclk/sdata DAC link at a programmable bit rate.
module funct_generator_fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  funct_generator_fifo_reader_if.slave bus
);
  localparam int HPW = $clog2(2 * DATA_WIDTH);
  localparam logic [HPW-1:0] HP_LAST = HPW'(2 * DATA_WIDTH - 1);
  localparam logic [HPW-1:0] HP_ONE = HPW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, SHIFT, GAP
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] shreg;
  logic [DIV_WIDTH-1:0]  h_q;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [HPW-1:0]        hp_cnt;
  logic [CNT_WIDTH-1:0]  frames;
  logic                  sclk_q;
  logic                  under_q;
  logic                  div_done;
  logic                  hp_last;
  logic                  start_ok;

  // h_q holds H-1, so a half-period spans div_cnt = 0..h_q
  assign div_done = (div_cnt == h_q);
  assign hp_last  = (hp_cnt == HP_LAST);
  assign start_ok = bus.en_i && !bus.fifo_empty_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_ok) state_n = POP;
      POP:   state_n = LOAD;
      LOAD:  state_n = SHIFT;
      SHIFT: if (div_done && hp_last) state_n = GAP;
      GAP:
        if (div_done) state_n = start_ok ? POP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      h_q     <= '0;
      div_cnt <= '0;
      hp_cnt  <= '0;
      frames  <= '0;
      sclk_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (!bus.en_i) under_q <= 1'b0;
        LOAD: begin
          shreg   <= bus.fifo_data_i;
          h_q     <= bus.clk_div_i;
          div_cnt <= '0;
          hp_cnt  <= '0;
          sclk_q  <= 1'b0;
        end
        SHIFT:
          if (div_done) begin
            div_cnt <= '0;
            hp_cnt  <= hp_cnt + HP_ONE;
            sclk_q  <= ~sclk_q;
            if (sclk_q)
              shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            if (hp_last) begin
              sclk_q <= 1'b0;
              frames <= frames + CNT_ONE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        GAP:
          if (div_done) begin
            div_cnt <= '0;
            if (bus.en_i && bus.fifo_empty_i)
              under_q <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en_o = (state == POP);
  assign bus.dac_csn_o    = (state != SHIFT);
  assign bus.dac_sclk_o   = sclk_q;
  assign bus.dac_sdata_o  = (state == SHIFT) && shreg[DATA_WIDTH-1];
  assign bus.busy_o       = (state != IDLE);
  assign bus.underrun_o   = under_q;
  assign bus.frame_cnt_o  = frames;
endmodule

// File: tb/tb_funct_generator_fifo_reader.sv
// Directed plus random stimulus for the FIFO reader, checked every
// cycle against a timeline model of the DAC frame.
module tb_funct_generator_fifo_reader;
  localparam int N  = 16;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  funct_generator_fifo_reader_if #(
    .DATA_WIDTH(N), .DIV_WIDTH(DW), .CNT_WIDTH(CW)
  ) bus ();

  funct_generator_fifo_reader #(
    .DATA_WIDTH(N), .DIV_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] fq[$];
  logic [N-1:0] mq[$];

  // model: a frame is a timeline of offsets from its POP cycle
  int cyc = 0;
  int st = 0;
  int mh = 1;
  int frames = 0;
  bit act = 1'b0;
  bit und = 1'b0;
  logic [N-1:0] w = '0;
  int md, ms;

  int lens[$];
  int gaps[$];
  int rises[$];
  logic [N-1:0] words[$];
  bit in_f, seen, ps;
  int len, hil, nr;
  logic [N-1:0] mw;

  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] v);
    fq.push_back(v);
    mq.push_back(v);
  endtask

  task automatic start_frame();
    act = 1'b1;
    st = cyc + 1;
    w = (mq.size() > 0) ? mq.pop_front() : '0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      act = 1'b0;
      und = 1'b0;
      frames = 0;
      mh = 1;
    end else begin
      if (!act) begin
        if (!bus.en_i) und = 1'b0;
        if (bus.en_i && !bus.fifo_empty_i) start_frame();
      end else begin
        md = cyc - st;
        if (md == 1) mh = int'(bus.clk_div_i) + 1;
        ms = 2 * N * mh;
        if (md == 1 + ms) frames++;
        if (md == 1 + ms + mh) begin
          if (bus.en_i && !bus.fifo_empty_i) start_frame();
          else begin
            act = 1'b0;
            if (bus.en_i) und = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  initial forever begin : compare
    int ed, es, hh;
    bit sh;
    @(negedge clk);
    ed = cyc - st;
    es = 2 * N * mh;
    sh = act && ed >= 2 && ed < 2 + es;
    hh = sh ? (ed - 2) / mh : 0;
    chk("rd_en", int'(bus.fifo_rd_en_o), int'(act && ed == 0));
    chk("csn", int'(bus.dac_csn_o), int'(!sh));
    chk("sclk", int'(bus.dac_sclk_o), sh ? hh % 2 : 0);
    chk("sdata", int'(bus.dac_sdata_o),
        sh ? int'(w[N-1-hh/2]) : 0);
    chk("busy", int'(bus.busy_o), int'(act));
    chk("underrun", int'(bus.underrun_o), int'(und));
    chk("frame_cnt", int'(bus.frame_cnt_o), frames % (1 << CW));
  end

  initial begin
    bus.fifo_data_i = '0;
    bus.fifo_empty_i = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (bus.fifo_rd_en_o) begin
        chk("pop_nonempty", int'(fq.size() > 0), 1);
        if (fq.size() > 0) bus.fifo_data_i = fq.pop_front();
      end
      bus.fifo_empty_i = (fq.size() == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      lens.delete(); gaps.delete();
      rises.delete(); words.delete();
      in_f = 0; seen = 0; ps = 0; hil = 0;
    end else begin
      if (!bus.dac_csn_o) begin
        if (!in_f) begin
          in_f = 1; len = 0; nr = 0; mw = '0;
          if (seen) gaps.push_back(hil);
        end
        len++;
        if (bus.dac_sclk_o && !ps) begin
          mw = {mw[N-2:0], bus.dac_sdata_o};
          nr++;
        end
      end else begin
        if (in_f) begin
          lens.push_back(len);
          words.push_back(mw);
          rises.push_back(nr);
          seen = 1; hil = 0; in_f = 0;
        end
        hil++;
      end
      ps = bus.dac_sclk_o;
    end
  end

  task automatic do_reset(input bit flush);
    @(posedge clk);
    #2 rst = 1'b1;
    if (flush) begin
      fq.delete();
      mq.delete();
    end
    #1;
    chk("rst_rd_en", int'(bus.fifo_rd_en_o), 0);
    chk("rst_csn", int'(bus.dac_csn_o), 1);
    chk("rst_sclk", int'(bus.dac_sclk_o), 0);
    chk("rst_sdata", int'(bus.dac_sdata_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_under", int'(bus.underrun_o), 0);
    chk("rst_frames", int'(bus.frame_cnt_o), 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit done = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < maxc; i++) begin
      if (!bus.busy_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_idle"}, int'(done), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] b2b[3];
    b2b[0] = 16'h0001;
    b2b[1] = 16'h8000;
    b2b[2] = 16'h7FFF;
    bus.en_i = 1'b0;
    bus.clk_div_i = 8'd1;
    repeat (2) @(negedge clk);

    do_reset(1);
    repeat (5) @(negedge clk);
    chk("idle_hold_csn", int'(bus.dac_csn_o), 1);
    push(16'hA5C3);
    bus.en_i = 1'b1;
    wait_idle(200, "single");
    chk("s1_frames", int'(bus.frame_cnt_o), 1);
    chk("s1_under", int'(bus.underrun_o), 1);
    chk("s1_n", lens.size(), 1);
    if (lens.size() > 0) begin
      chk("s1_len", lens[0], 64);
      chk("s1_word", int'(words[0]), 16'hA5C3);
      chk("s1_rises", rises[0], 16);
    end

    bus.en_i = 1'b0;
    do_reset(1);
    bus.clk_div_i = 8'd0;
    foreach (b2b[i]) push(b2b[i]);
    bus.en_i = 1'b1;
    wait_idle(300, "b2b");
    chk("b2b_frames", int'(bus.frame_cnt_o), 3);
    chk("b2b_n", lens.size(), 3);
    chk("b2b_ngap", gaps.size(), 2);
    foreach (lens[i]) chk("b2b_len", lens[i], 32);
    foreach (gaps[i]) chk("b2b_gap", gaps[i], 3);
    foreach (words[i])
      if (i < 3) chk("b2b_word", int'(words[i]), int'(b2b[i]));

    bus.en_i = 1'b0;
    do_reset(1);
    bus.clk_div_i = 8'd1;
    push(16'h1234);
    push(16'h5678);
    bus.en_i = 1'b1;
    repeat (26) @(negedge clk);
    bus.en_i = 1'b0;
    wait_idle(200, "drop");
    chk("drop_frames", int'(bus.frame_cnt_o), 1);
    chk("drop_under", int'(bus.underrun_o), 0);
    chk("drop_left", fq.size(), 1);
    chk("drop_n", lens.size(), 1);
    if (lens.size() > 0) begin
      chk("drop_len", lens[0], 64);
      chk("drop_word", int'(words[0]), 16'h1234);
    end

    do_reset(1);
    bus.clk_div_i = 8'd1;
    push(16'hC0DE);
    push(16'h3A5F);
    bus.en_i = 1'b1;
    repeat (10) @(negedge clk);
    bus.clk_div_i = 8'd3;
    wait_idle(400, "div");
    chk("div_n", lens.size(), 2);
    if (lens.size() > 1) begin
      chk("div_len0", lens[0], 64);
      chk("div_len1", lens[1], 128);
      chk("div_word1", int'(words[1]), 16'h3A5F);
    end

    bus.en_i = 1'b0;
    do_reset(1);
    bus.clk_div_i = 8'd255;
    push(16'h8001);
    bus.en_i = 1'b1;
    wait_idle(9000, "maxdiv");
    chk("max_n", lens.size(), 1);
    if (lens.size() > 0) begin
      chk("max_len", lens[0], 8192);
      chk("max_word", int'(words[0]), 16'h8001);
    end

    bus.en_i = 1'b0;
    do_reset(1);
    bus.clk_div_i = 8'd0;
    push(16'h0F0F);
    bus.en_i = 1'b1;
    wait_idle(100, "pre");
    chk("pre_frames", int'(bus.frame_cnt_o), 1);
    push(16'hAAAA);
    push(16'h5555);
    repeat (17) @(negedge clk);
    chk("mid_csn", int'(bus.dac_csn_o), 0);
    do_reset(0);
    wait_idle(100, "post");
    chk("post_frames", int'(bus.frame_cnt_o), 1);
    chk("post_n", words.size(), 1);
    if (words.size() > 0)
      chk("post_word", int'(words[0]), 16'h5555);

    bus.en_i = 1'b0;
    do_reset(1);
    bus.clk_div_i = 8'd0;
    bus.en_i = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0 && fq.size() < 4)
        push(16'($urandom));
      if ($urandom_range(0, 63) == 0)
        bus.en_i = ~bus.en_i;
      if ($urandom_range(0, 40) == 0)
        bus.clk_div_i = 8'($urandom_range(0, 2));
    end
    bus.en_i = 1'b0;
    wait_idle(400, "rand");
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/funct_generator_fifo_reader.md
Name: funct_generator_fifo_reader

Overview:
Consumer end of the sample FIFO that the function generator fills. The block pops signed samples from the FIFO and serialises each one MSB-first onto a 3-wire DAC interface (csn/sclk/sdata), with a programmable bit rate. It sits between the FIFO read port and the chip-level DAC pins. It also reports busy, underrun and a completed-frame count.

Parameters:
DATA_WIDTH, 16, sample width; equals the FIFO word width.
DIV_WIDTH, 8, width of the sclk half-period divider input.
CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset, asynchronous, active-high.
en_i  input  1  streaming enable.
clk_div_i  input  DIV_WIDTH  half-period H = clk_div_i+1 clk cycles.
fifo_empty_i  input  1  FIFO empty flag.
fifo_data_i  input  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en_o.
fifo_rd_en_o  output  1  FIFO pop strobe, 1-cycle pulse.
dac_csn_o  output  1  DAC chip select, active-low.
dac_sclk_o  output  1  DAC serial clock, idle low.
dac_sdata_o  output  1  DAC serial data.
busy_o  output  1  high in any state other than IDLE.
underrun_o  output  1  sticky stream-starved flag.
frame_cnt_o  output  CNT_WIDTH  number of frames completed; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset, asynchronous with immediate effect: state=IDLE, fifo_rd_en_o=0, dac_csn_o=1, dac_sclk_o=0, dac_sdata_o=0, busy_o=0, underrun_o=0, frame_cnt_o=0. The shift register and divider counter clear to 0.
- All outputs are registered or Moore-decoded from registered state. There is no combinational path from input to output.
- FSM states: IDLE, POP, LOAD, SHIFT, GAP.
- IDLE:
  - Go to POP when en_i=1 and fifo_empty_i=0.
  - If en_i=0, clear underrun_o.
- POP: fifo_rd_en_o=1 for this single cycle. Next state is LOAD unconditionally.
- LOAD:
  - Capture fifo_data_i into the shift register.
  - Latch H from clk_div_i. H is held for the whole frame; changes to clk_div_i mid-frame take effect from the next LOAD.
  - Next state is SHIFT.
- SHIFT:
  - dac_csn_o=0 and the divider counts H cycles per half-period.
  - The first half-period has sclk=0 and sdata=MSB.
  - At each half-period expiry sclk toggles. On each falling toggle the next bit is presented.
  - The DAC samples on the rising edge.
  - Exactly DATA_WIDTH rising edges occur per frame, and SHIFT lasts 2*DATA_WIDTH*H cycles. The last half-period has sclk=1.
  - At its expiry: sclk returns to 0, sdata returns to 0, and the state goes to GAP.
- GAP:
  - dac_csn_o=1 for H cycles; frame_cnt_o increments on entry.
  - At GAP end:
    - en_i=1 and fifo_empty_i=0 goes to POP (back-to-back).
    - en_i=1 and fifo_empty_i=1 sets underrun_o and goes to IDLE.
    - en_i=0 goes to IDLE.
- Latency: if en_i=1 and fifo_empty_i=0 are sampled in IDLE at edge k, then POP runs in cycle k+1, LOAD in k+2, and csn falls at k+3.
- Minimum csn-high time between back-to-back frames is H+2 cycles (GAP+POP+LOAD).
- en_i deasserted mid-frame: the current frame completes fully, no further pop occurs, and underrun_o is not set.
- fifo_empty_i is ignored in POP, LOAD and SHIFT. Data is never dropped after a pop.
- The FIFO is never popped while empty; popping is gated in IDLE and at GAP end.
- Data is transmitted as raw two's-complement bits with no conversion.
- clk_div_i=0 gives H=1, so sclk=clk/2. The maximum value of clk_div_i gives H=2^DIV_WIDTH.
- Reset asserted mid-frame aborts the frame. csn=1 and sclk=0 take effect without waiting for a clock edge. No partial frame is counted.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs equal their reset values immediately; after release with en_i=0, outputs hold.
- Single sample: FIFO={16'hA5C3}, clk_div_i=1, en_i=1 held -> one rd_en pulse, csn low 64 cycles, 16 rising edges carrying 1010_0101_1100_0011, csn high, frame_cnt_o=1, underrun_o=1 at GAP end.
- Back-to-back: FIFO={16'h0001,16'h8000,16'h7FFF}, clk_div_i=0 -> three frames of 32 cycles each, csn high exactly 3 cycles between frames, bits match, frame_cnt_o=3.
- Enable drop: two samples queued, deassert en_i during bit 5 of frame 1 -> frame 1 completes all 16 bits, no second rd_en, underrun_o=0, busy_o=0 after GAP.
- Divider change: clk_div_i changed 1->3 during frame 1 -> frame 1 sclk half-period 2 cycles, frame 2 half-period 4 cycles (csn low 128 cycles).
- Reset mid-shift: assert rst during bit 7 -> csn=1, sclk=0 instantly and frame_cnt_o=0; after release with the FIFO non-empty, a new frame starts with POP at cycle k+1.
